// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PHY TX symbols, striper FSM states and link-width clamp helper
package pcie_phy_pkg;

    localparam logic [7:0] K_COM      = 8'hBC;
    localparam logic [7:0] K_SKP      = 8'h1C;
    localparam logic [7:0] D_IDLE     = 8'h00;
    localparam int         SKP_OS_LEN = 4;

    typedef enum logic [1:0] {
        S_DOWN,
        S_RUN,
        S_SKP
    } tx_stripe_state_e;

    // Returns log2 of the active lane count; oversized selections saturate at the widest link.
    function automatic int clamp_width(input int sel, input int max_log);
        return (sel > max_log) ? max_log : sel;
    endfunction

endpackage

// File: rtl/pcie_sync_fifo.sv
// rtl/pcie_sync_fifo.sv - single-clock FIFO with flush, registered occupancy and show-ahead head word
module pcie_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign push_ok   = push && !full && !flush;
    assign pop_ok    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcie_tx_lane_striper.sv
// rtl/pcie_tx_lane_striper.sv - buffers MAC frames and stripes them byte-wise over x1..xN lanes with idle fill
// SKP ordered-set insertion is built only when PCIE_TX_SKP_INSERT_EN is defined.
module pcie_tx_lane_striper #(
    parameter int NUM_LANES       = 4,
    parameter int MAC_FRAME_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int SKP_INTERVAL    = 1180
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          link_up_i,
    input  logic [$clog2(NUM_LANES):0]    link_width_sel_i,
    input  logic [MAC_FRAME_WIDTH-1:0]    mac_data_frame_i,
    input  logic                          mac_data_frame_valid_i,
    output logic                          mac_data_frame_ready_o,
    input  logic                          lane_ready_i,
    output logic [8*NUM_LANES-1:0]        lane_symbol_o,
    output logic [NUM_LANES-1:0]          lane_is_k_o,
    output logic [NUM_LANES-1:0]          lane_symbol_valid_o,
    output logic                          is_ordered_set_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    import pcie_phy_pkg::*;

    localparam int LOG_N = $clog2(NUM_LANES);
    localparam int SEL_W = LOG_N + 1;
    localparam int PTR_W = (LOG_N > 0) ? LOG_N : 1;

    if (MAC_FRAME_WIDTH != 8 * NUM_LANES || FIFO_DEPTH < 2 || SKP_INTERVAL < 8) begin : g_param_check
        $error("pcie_tx_lane_striper: illegal parameter combination");
    end

    tx_stripe_state_e           state;
    logic [SEL_W-1:0]           width_log;
    logic [SEL_W-1:0]           sel_clamped;
    logic [PTR_W-1:0]           ptr;
    logic [1:0]                 os_idx;
    logic [MAC_FRAME_WIDTH-1:0] head_data;
    logic [7:0]                 frame_bytes [NUM_LANES];
    logic [NUM_LANES-1:0]       active_mask;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       ptr_at_last;
    logic                       take_skp;
    logic [8*NUM_LANES-1:0]     nxt_symbol;
    logic [NUM_LANES-1:0]       nxt_is_k;
    logic [NUM_LANES-1:0]       nxt_valid;
    logic                       nxt_os;

    assign sel_clamped            = SEL_W'(clamp_width(int'(link_width_sel_i), LOG_N));
    assign mac_data_frame_ready_o = link_up_i && !fifo_full;
    assign fifo_push              = mac_data_frame_valid_i && mac_data_frame_ready_o;
    assign ptr_at_last            = (int'(ptr) == ((NUM_LANES >> width_log) - 1));
    assign fifo_pop               = link_up_i && lane_ready_i && (state == S_RUN)
                                    && !take_skp && ptr_at_last;

    pcie_sync_fifo #(
        .WIDTH (MAC_FRAME_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (!link_up_i),
        .push      (fifo_push),
        .push_data (mac_data_frame_i),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

`ifdef PCIE_TX_SKP_INSERT_EN
    localparam int CNT_W = $clog2(SKP_INTERVAL);

    logic [CNT_W-1:0] skp_cnt;
    logic             skp_pend;
    logic             skp_hit;

    assign skp_hit  = (skp_cnt == CNT_W'(SKP_INTERVAL - 1));
    assign take_skp = skp_pend && (ptr == '0);

    // A newly expiring interval re-arms the request even in the cycle an older one is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skp_cnt  <= '0;
            skp_pend <= 1'b0;
        end else if (!link_up_i) begin
            skp_cnt  <= '0;
            skp_pend <= 1'b0;
        end else if (lane_ready_i && state != S_DOWN) begin
            skp_cnt  <= skp_hit ? '0 : skp_cnt + CNT_W'(1);
            skp_pend <= (skp_pend && !(state == S_RUN && take_skp)) || skp_hit;
        end
    end
`else
    assign take_skp = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            frame_bytes[k] = head_data[8*k +: 8];
            active_mask[k] = ((k >> width_log) == 0);
        end
    end

    always_comb begin
        nxt_symbol = '0;
        nxt_is_k   = '0;
        nxt_valid  = '0;
        nxt_os     = 1'b0;
        if (state != S_DOWN) begin
            nxt_valid = active_mask;
        end
        if ((state == S_RUN && take_skp) || state == S_SKP) begin
            nxt_os   = 1'b1;
            nxt_is_k = active_mask;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            if (active_mask[k]) begin
                if (state == S_SKP) begin
                    nxt_symbol[8*k +: 8] = K_SKP;
                end else if (state == S_RUN && take_skp) begin
                    nxt_symbol[8*k +: 8] = K_COM;
                end else if (state == S_RUN && !fifo_empty) begin
                    nxt_symbol[8*k +: 8] = frame_bytes[PTR_W'((int'(ptr) << width_log) + k)];
                end else begin
                    nxt_symbol[8*k +: 8] = D_IDLE;
                end
            end
        end
    end

    // Link loss is honoured on any cycle; everything else waits for a symbol time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= S_DOWN;
            width_log           <= '0;
            ptr                 <= '0;
            os_idx              <= '0;
            lane_symbol_o       <= '0;
            lane_is_k_o         <= '0;
            lane_symbol_valid_o <= '0;
            is_ordered_set_o    <= 1'b0;
        end else if (!link_up_i) begin
            if (state == S_DOWN) begin
                width_log <= sel_clamped;
            end
            state               <= S_DOWN;
            ptr                 <= '0;
            os_idx              <= '0;
            lane_symbol_o       <= '0;
            lane_is_k_o         <= '0;
            lane_symbol_valid_o <= '0;
            is_ordered_set_o    <= 1'b0;
        end else begin
            if (state == S_DOWN) begin
                width_log <= sel_clamped;
            end
            if (lane_ready_i) begin
                lane_symbol_o       <= nxt_symbol;
                lane_is_k_o         <= nxt_is_k;
                lane_symbol_valid_o <= nxt_valid;
                is_ordered_set_o    <= nxt_os;
                case (state)
                    S_DOWN: state <= S_RUN;
                    S_RUN: begin
                        if (take_skp) begin
                            state  <= S_SKP;
                            os_idx <= 2'd1;
                        end else if (!fifo_empty) begin
                            ptr <= ptr_at_last ? '0 : ptr + PTR_W'(1);
                        end
                    end
                    S_SKP: begin
                        if (os_idx == 2'(SKP_OS_LEN - 1)) begin
                            state  <= S_RUN;
                            os_idx <= '0;
                        end else begin
                            os_idx <= os_idx + 2'd1;
                        end
                    end
                    default: state <= S_DOWN;
                endcase
            end
        end
    end

endmodule

// File: doc/pcie_tx_lane_striper.md
Name: pcie_tx_lane_striper

Overview:
- Parametrised TX byte striper between the Data Link Layer frame interface and the per-lane encoders/scramblers of the physical layer.
- Buffers MAC frames in a small FIFO and stripes them byte-wise across a run-time selectable link width (x1..xNUM_LANES).
- Emits logical idle when no data is available and periodically inserts SKP ordered sets at frame boundaries.

Parameters:
- NUM_LANES, 4, physical lanes; power of 2, 1..16.
- MAC_FRAME_WIDTH, 32, input frame width; must equal 8*NUM_LANES.
- FIFO_DEPTH, 4, frame FIFO entries; power of 2, >=2.
- SKP_INTERVAL, 1180, symbol times between SKP ordered sets; >= 8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- link_up_i  in  1  link trained; low = flush and hold.
- link_width_sel_i  in  $clog2(NUM_LANES)+1  active lanes = 2**sel; values above log2(NUM_LANES) clamp to NUM_LANES.
- mac_data_frame_i  in  MAC_FRAME_WIDTH  frame, byte0 = bits[7:0].
- mac_data_frame_valid_i  in  1  frame valid.
- mac_data_frame_ready_o  out  1  frame accepted when valid&ready.
- lane_ready_i  in  1  downstream takes one symbol per lane this cycle (all lanes together).
- lane_symbol_o  out  8*NUM_LANES  lane k symbol at bits [8k+7:8k].
- lane_is_k_o  out  NUM_LANES  symbol is a K-code.
- lane_symbol_valid_o  out  NUM_LANES  symbol valid, active lanes only.
- is_ordered_set_o  out  1  current output is part of an SKP OS.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, byte pointer 0, SKP counter 0, FSM = S_DOWN. Reset mid-frame discards the partial frame.
- Clock enable:
  - All state advances only when lane_ready_i=1 (a "symbol time").
  - Exceptions: FIFO push, and link_up_i falling, which acts immediately.
  - Output registers hold while lane_ready_i=0.
- mac_data_frame_ready_o = link_up_i & !full. No push-through bypass when full.
- Simultaneous push and pop when not full: both occur; level is unchanged.
- FSM states:
  - S_DOWN:
    - Outputs valid=0.
    - FIFO is held flushed.
    - width = clamp(link_width_sel_i) is registered every cycle.
    - On link_up_i=1, go to S_RUN. Width is then frozen until the next S_DOWN.
  - S_RUN (each symbol time):
    - Head frame present: emit bytes [ptr*W +: W] on lanes 0..W-1 (W = active lanes), is_k=0.
    - ptr increments modulo NUM_LANES/W. On wrap, the frame is popped.
    - FIFO empty at ptr=0: emit logical idle 8'h00, is_k=0, on all active lanes.
  - SKP pending:
    - Set when the SKP counter reaches SKP_INTERVAL-1; the counter then restarts from 0.
    - Taken only at ptr=0, i.e. never inside a frame. Go to S_SKP.
  - S_SKP:
    - 4 symbol times: COM 8'hBC, then SKP 8'h1C x3, all with is_k=1, on all active lanes; is_ordered_set_o=1.
    - FIFO keeps accepting frames but is not popped.
    - Return to S_RUN.
  - Any state with link_up_i=0: next cycle go to S_DOWN, FIFO flushed, pending SKP cleared, counter 0.
- Inactive lanes (index >= W): symbol 0, is_k 0, valid 0.
- lane_symbol_valid_o = active-lane mask, registered, in S_RUN/S_SKP on every symbol time.
- Latency: frame accepted at edge N into an empty FIFO with lane_ready_i=1 and no SKP → byte0 on lane_symbol_o after edge N+1. xW frame occupies NUM_LANES/W symbol times.
- fifo_level_o registered, 0..FIFO_DEPTH.

Optional Feature:
- Macro PCIE_TX_SKP_INSERT_EN.
- Defined: SKP counter and S_SKP present, as above.
- Undefined:
  - No counter, S_SKP unreachable.
  - is_ordered_set_o tied 0.
  - lane_is_k_o always 0 (only data/idle emitted).

Decomposition:
- Package pcie_phy_pkg:
  - Constants: K_COM=8'hBC, K_SKP=8'h1C, D_IDLE=8'h00, SKP_OS_LEN=4.
  - Enum tx_stripe_state_e {S_DOWN, S_RUN, S_SKP}.
  - Function clamp_width.
- Sub-module pcie_sync_fifo:
  - Parametrised width/depth, push/pop/flush, full/empty/level.
  - Instantiated once.

Test Plan:
- x4 (sel=2), push 32'hDDCCBBAA, lane_ready_i=1 → next symbol time lanes0..3 = AA,BB,CC,DD, valid=4'b1111, then idle 00s.
- x1 (sel=0), push 32'h44332211 and 32'h88776655 back-to-back → lane0 emits 11,22,33,44,55,66,77,88 on consecutive symbol times; lanes1..3 valid=0.
- x2, FIFO_DEPTH=4, push 5 frames with lane_ready_i=0 → 5th push stalls (ready_o=0, level=4); raise lane_ready_i → frames drain in order, 2 symbol times each.
- SKP_INTERVAL=8, x2, continuous frames → SKP OS (BC,1C,1C,1C, is_k=1, is_ordered_set_o=1) inserted only at a frame boundary; no frame byte lost or duplicated.
- Drop link_up_i mid-frame at x1 ptr=2 → next cycle valid=0, level=0, ready_o=0; relink at x4 → fresh frames output from byte0.
- Assert rst_i asynchronously mid-SKP → all outputs 0 immediately, FSM S_DOWN, no residual K symbols after release.
